// File: rtl/debounce_scan_ctrl.sv
// Time-shared debouncer: one evaluation datapath visits each raw input in turn
// and reports debounced level changes on a valid/ready event port.
module debounce_scan_ctrl #(
    parameter int N_INPUTS   = 4,
    parameter int STABLE_CNT = 4,
    parameter int ID_W       = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [N_INPUTS-1:0] in_raw,
    output logic [N_INPUTS-1:0] level,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [ID_W-1:0]     evt_id,
    output logic                evt_level
);

    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
    localparam logic [CW-1:0] CNT_TOP = CW'(STABLE_CNT - 1);
    localparam logic [ID_W-1:0] PTR_LAST = ID_W'(N_INPUTS - 1);

    logic [N_INPUTS-1:0] sync_q1;
    logic [N_INPUTS-1:0] sync_q2;
    logic [N_INPUTS-1:0] last;
    logic [CW-1:0]       cnt [N_INPUTS];
    logic [ID_W-1:0]     ptr;

    logic          stall;
    logic          visit;
    logic          cur_sync;
    logic          cur_last;
    logic          cur_lvl;
    logic [CW-1:0] cur_cnt;
    logic          changed;
    logic          bump;
    logic          accept;
    logic          valid_nxt;

    always_comb begin
        stall    = evt_valid & ~evt_ready;
        visit    = en & ~stall;
        cur_sync = sync_q2[ptr];
        cur_last = last[ptr];
        cur_lvl  = level[ptr];
        cur_cnt  = cnt[ptr];
        changed  = cur_sync != cur_last;
        bump     = visit & ~changed & (cur_cnt < CNT_MAX);
        // Accept only on the increment that reaches the threshold.
        accept   = bump & (cur_cnt == CNT_TOP) & (cur_last != cur_lvl);
        valid_nxt = accept | stall;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1   <= '0;
            sync_q2   <= '0;
            last      <= '0;
            level     <= '0;
            ptr       <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_level <= 1'b0;
            for (int k = 0; k < N_INPUTS; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            sync_q1 <= in_raw;
            sync_q2 <= sync_q1;
            if (visit) begin
                if (changed) begin
                    last[ptr] <= cur_sync;
                    cnt[ptr]  <= '0;
                end else if (bump) begin
                    cnt[ptr] <= cur_cnt + 1'b1;
                end
                if (accept) begin
                    level[ptr] <= cur_last;
                end
                ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
            end
            evt_valid <= valid_nxt;
            if (accept) begin
                evt_id    <= ptr;
                evt_level <= cur_last;
            end
        end
    end

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Bench for debounce_scan_ctrl: vector table, directed corner sequences and
// randomized traffic checked cycle by cycle against a behavioural model.
module tb_debounce_scan_ctrl;

    localparam int N  = 4;
    localparam int SC = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic [N-1:0]  in_raw = '0;
    logic [N-1:0]  level;
    logic          evt_valid;
    logic          evt_ready = 1'b1;
    logic [IW-1:0] evt_id;
    logic          evt_level;

    always #5 clk = ~clk;

    debounce_scan_ctrl #(
        .N_INPUTS  (N),
        .STABLE_CNT(SC),
        .ID_W      (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_raw   (in_raw),
        .level    (level),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_id   (evt_id),
        .evt_level(evt_level)
    );

    int checks = 0;
    int errors = 0;
    int xfers  = 0;

    // Behavioural model: raw history for the two-clock delay, per-input
    // candidate value and length of its matching run, plus one event slot.
    bit [N-1:0] m_hist[$];
    bit         m_cand[N];
    int         m_run[N];
    bit         m_lvl[N];
    int         m_ptr;
    bit         m_valid;
    int         m_id;
    bit         m_evl;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic model_step();
        bit [N-1:0] seen;
        bit blocked;
        bit nv;
        int i;
        if (rst) begin
            m_hist.delete();
            m_hist.push_back('0);
            m_hist.push_back('0);
            for (int k = 0; k < N; k++) begin
                m_cand[k] = 0;
                m_run[k]  = 0;
                m_lvl[k]  = 0;
            end
            m_ptr   = 0;
            m_valid = 0;
            m_id    = 0;
            m_evl   = 0;
            return;
        end
        seen    = m_hist[0];
        blocked = m_valid && !evt_ready;
        nv      = blocked;
        if (en && !blocked) begin
            i = m_ptr;
            if (seen[i] != m_cand[i]) begin
                m_cand[i] = seen[i];
                m_run[i]  = 0;
            end else if (m_run[i] < SC) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == SC && m_cand[i] != m_lvl[i]) begin
                    m_lvl[i] = m_cand[i];
                    nv    = 1;
                    m_id  = i;
                    m_evl = m_cand[i];
                end
            end
            m_ptr = (m_ptr + 1) % N;
        end
        m_valid = nv;
        void'(m_hist.pop_front());
        m_hist.push_back(in_raw);
    endtask

    task automatic tick();
        logic [N-1:0] lv;
        if (!rst && evt_valid && evt_ready) xfers++;
        model_step();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) lv[k] = m_lvl[k];
        chk("model_level", 32'(level), 32'(lv));
        chk("model_valid", 32'(evt_valid), 32'(m_valid));
        if (m_valid) begin
            chk("model_id", 32'(evt_id), 32'(m_id));
            chk("model_evl", 32'(evt_level), 32'(m_evl));
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Waits up to lim edges for evt_valid; returns edges taken or lim+1.
    task automatic wait_evt(input int lim, output int took);
        took = lim + 1;
        for (int k = 1; k <= lim; k++) begin
            tick();
            if (evt_valid) begin
                took = k;
                break;
            end
        end
    endtask

    task automatic count_evts(input int n, output int c);
        c = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (evt_valid) c++;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        ticks(n);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] raw;
        logic         en;
        int           cycles;
        logic [N-1:0] exp_level;
        int           exp_xfers;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int took;
        int c;
        int base;

        tbl[0] = '{4'b0100, 1'b1, 30, 4'b0100, 1};
        tbl[1] = '{4'b0110, 1'b1, 30, 4'b0110, 2};
        tbl[2] = '{4'b0010, 1'b1, 30, 4'b0010, 3};
        tbl[3] = '{4'b1011, 1'b1, 30, 4'b1011, 5};
        tbl[4] = '{4'b0000, 1'b0, 30, 4'b1011, 5};
        tbl[5] = '{4'b0000, 1'b1, 30, 4'b0000, 8};

        // Reset with all lines high, then first event after release.
        in_raw    = 4'b1111;
        evt_ready = 1'b1;
        en        = 1'b1;
        do_reset(3);
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_valid", 32'(evt_valid), 32'(0));
        chk("rst_id", 32'(evt_id), 32'(0));
        wait_evt(30, took);
        chk("rst_first_lat_ok", 32'(took >= 1 && took <= 22), 32'(1));
        chk("rst_first_evl", 32'(evt_level), 32'(1));
        ticks(30);
        chk("rst_all_high", 32'(level), 32'(4'b1111));

        // Vector table from a clean reset with all lines low.
        in_raw = '0;
        do_reset(2);
        ticks(4);
        base = xfers;
        for (int v = 0; v < 6; v++) begin
            in_raw = tbl[v].raw;
            en     = tbl[v].en;
            ticks(tbl[v].cycles);
            chk("tbl_level", 32'(level), 32'(tbl[v].exp_level));
            chk("tbl_xfers", 32'(xfers - base), 32'(tbl[v].exp_xfers));
        end
        en = 1'b1;

        // Clean press on input 2.
        in_raw = 4'b0100;
        wait_evt(30, took);
        chk("press_lat_window", 32'(took >= 19 && took <= 22), 32'(1));
        chk("press_id", 32'(evt_id), 32'(2));
        chk("press_evl", 32'(evt_level), 32'(1));
        tick();
        chk("press_single_pulse", 32'(evt_valid), 32'(0));
        chk("press_level", 32'(level), 32'(4'b0100));
        count_evts(30, c);
        chk("press_no_extra", 32'(c), 32'(0));

        // Bounce on input 1, then a clean hold, then a short glitch.
        in_raw = '0;
        ticks(30);
        c = 0;
        for (int t = 0; t < 30; t++) begin
            if (t % 3 == 0) in_raw[1] = ~in_raw[1];
            tick();
            if (evt_valid) c++;
        end
        chk("bounce_quiet", 32'(c), 32'(0));
        in_raw[1] = 1'b1;
        wait_evt(30, took);
        chk("bounce_lat_ok", 32'(took <= 22), 32'(1));
        chk("bounce_id", 32'(evt_id), 32'(1));
        chk("bounce_evl", 32'(evt_level), 32'(1));
        count_evts(30, c);
        chk("bounce_single", 32'(c), 32'(0));
        in_raw[1] = 1'b0;
        count_evts(5, c);
        in_raw[1] = 1'b1;
        begin
            int c2;
            count_evts(40, c2);
            c += c2;
        end
        chk("glitch_no_evt", 32'(c), 32'(0));
        chk("glitch_level", 32'(level), 32'(4'b0010));

        // Backpressure: inputs 0 and 3 rise together while stalled.
        in_raw    = '0;
        evt_ready = 1'b0;
        do_reset(2);
        ticks(2);
        in_raw = 4'b1001;
        wait_evt(40, took);
        chk("bp_first_seen", 32'(took <= 40), 32'(1));
        chk("bp_first_id", 32'(evt_id), 32'(0));
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("bp_id_stable", 32'(evt_id), 32'(0));
            chk("bp_lvl3_held", 32'(level[3]), 32'(0));
        end
        base      = xfers;
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("bp_one_xfer", 32'(xfers - base), 32'(1));
        wait_evt(4 + SC * 4, took);
        chk("bp_second_bound", 32'(took <= 4 + SC * 4), 32'(1));
        chk("bp_second_id", 32'(evt_id), 32'(3));
        evt_ready = 1'b1;
        ticks(4);

        // Back-to-back accepts on consecutive visits.
        in_raw = '0;
        do_reset(2);
        ticks(2);
        in_raw = 4'b0011;
        wait_evt(30, took);
        chk("b2b_first_id", 32'(evt_id), 32'(0));
        tick();
        chk("b2b_valid_held", 32'(evt_valid), 32'(1));
        chk("b2b_second_id", 32'(evt_id), 32'(1));
        tick();
        chk("b2b_drained", 32'(evt_valid), 32'(0));

        // Enable dropped while input 2 settles.
        in_raw = 4'b0111;
        ticks(8);
        en = 1'b0;
        count_evts(30, c);
        chk("en_off_no_evt", 32'(c), 32'(0));
        chk("en_off_level", 32'(level), 32'(4'b0011));
        en = 1'b1;
        wait_evt(30, took);
        chk("en_resume_seen", 32'(took <= 30), 32'(1));
        chk("en_resume_id", 32'(evt_id), 32'(2));

        // Reset while an event is pending.
        evt_ready = 1'b0;
        in_raw    = '0;
        wait_evt(40, took);
        chk("rstmid_pending", 32'(evt_valid), 32'(1));
        base = xfers;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
        chk("rstmid_valid_drop", 32'(evt_valid), 32'(0));
        chk("rstmid_level", 32'(level), 32'(0));
        chk("rstmid_no_xfer", 32'(xfers - base), 32'(0));

        // Randomized traffic against the model.
        evt_ready = 1'b1;
        do_reset(2);
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0)
                in_raw[$urandom_range(0, N - 1)] ^= 1'b1;
            en        = ($urandom_range(0, 9) != 0);
            evt_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
